lbp_param: RTL and testbench

LBP_PARAM -- requirements
Module: lbp_param

---
 rtl/lbp_pkg.sv | 27 ++
 rtl/lbp_if.sv | 31 +++
 rtl/lbp_cmp.sv | 41 ++++
 rtl/lbp_param.sv | 225 ++++++++++++++++++++++
 tb/tb_lbp_param.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbp_pkg.sv
// ---------------------------------------------------------------------------
// lbp_pkg
// Shared definitions for the LBP engine: the control FSM state enumeration
// and the bit position of each neighbour inside the 8-bit LBP code.
// No ports (package).
// ---------------------------------------------------------------------------
package lbp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        EMIT,
        DONE
    } state_e;

    // Neighbour -> code bit mapping (window is addressed [row][col], 0..2).
    localparam int BIT_TL = 0;
    localparam int BIT_T  = 1;
    localparam int BIT_TR = 2;
    localparam int BIT_L  = 3;
    localparam int BIT_R  = 4;
    localparam int BIT_BL = 5;
    localparam int BIT_B  = 6;
    localparam int BIT_BR = 7;

endpackage

// File: rtl/lbp_if.sv
// ---------------------------------------------------------------------------
// lbp_if
// Bus bundle of the LBP engine: the gray-pixel read port (request/ready,
// data one cycle after accept) and the LBP result stream (valid/ready).
//   master : the LBP engine side (issues reads, produces results)
//   slave  : the memory / result-sink side
// ---------------------------------------------------------------------------
interface lbp_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 14
);
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_ready;
    logic [PIX_W-1:0]  gray_data;

    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              lbp_ready;

    modport master (
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
        input  gray_ready, gray_data, lbp_ready
    );

    modport slave (
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
        output gray_ready, gray_data, lbp_ready
    );
endinterface

// File: rtl/lbp_cmp.sv
// ---------------------------------------------------------------------------
// lbp_cmp
// Purely combinational comparator bank: turns a 3x3 window into an 8-bit
// LBP code.
//   win  : 3x3 window, pixel (r,c) at bits [(r*3+c)*PIX_W +: PIX_W]
//   mode : 0 = neighbour >= center, 1 = neighbour >= center + thr
//   thr  : threshold used in mode 1
//   code : LBP code, bit order given by lbp_pkg BIT_* constants
// ---------------------------------------------------------------------------
module lbp_cmp
    import lbp_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [9*PIX_W-1:0] win,
    input  logic               mode,
    input  logic [PIX_W-1:0]   thr,
    output logic [7:0]         code
);

    logic [PIX_W:0] ref_lvl;

    function automatic logic [PIX_W:0] pix(input logic [9*PIX_W-1:0] w, input int idx);
        return {1'b0, w[idx*PIX_W +: PIX_W]};
    endfunction

    always_comb begin
        // One extra bit so center+thr never wraps back below a bright neighbour.
        ref_lvl      = pix(win, 4) + (mode ? {1'b0, thr} : '0);
        code         = '0;
        code[BIT_TL] = pix(win, 0) >= ref_lvl;
        code[BIT_T]  = pix(win, 1) >= ref_lvl;
        code[BIT_TR] = pix(win, 2) >= ref_lvl;
        code[BIT_L]  = pix(win, 3) >= ref_lvl;
        code[BIT_R]  = pix(win, 5) >= ref_lvl;
        code[BIT_BL] = pix(win, 6) >= ref_lvl;
        code[BIT_B]  = pix(win, 7) >= ref_lvl;
        code[BIT_BR] = pix(win, 8) >= ref_lvl;
    end

endmodule

// File: rtl/lbp_param.sv
// ---------------------------------------------------------------------------
// lbp_param
// Frame-level LBP engine. Walks the interior pixels of an IMG_W x IMG_H
// image row-major, fetching a 3x3 window through the gray read port
// (9 reads at the start of each row, 3 reads per step to the right) and
// emitting one LBP code per interior pixel on the result stream.
//   clk, reset : clock, asynchronous active-high reset
//   start      : frame start (sampled in IDLE only)
//   mode, thr  : compare mode / threshold, latched at start
//   busy       : frame in progress (start acceptance through finish cycle)
//   finish     : one-cycle pulse when the frame completes
//   bus        : lbp_if master (gray read port + LBP result stream)
// ---------------------------------------------------------------------------
module lbp_param
    import lbp_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [PIX_W-1:0] thr,
    output logic             busy,
    output logic             finish,
    lbp_if.master            bus
);

    // IMG_W is a power of two, so an address is simply {row, col}.
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = ADDR_W - COL_W;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 2);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [1:0]         rd_r_q, rd_r_d, rd_c_q, rd_c_d;
    logic [3:0]         rd_cnt_q, rd_cnt_d;
    logic               cap_vld_q, cap_vld_d, cap_last_q, cap_last_d;
    logic [1:0]         cap_r_q, cap_r_d, cap_c_q, cap_c_d;
    logic               mode_q, mode_d;
    logic [PIX_W-1:0]   thr_q, thr_d;
    logic [PIX_W-1:0]   win_q [3][3];
    logic [PIX_W-1:0]   win_d [3][3];
    logic [ADDR_W-1:0]  lbp_addr_q, lbp_addr_d;
    logic [7:0]         lbp_data_q, lbp_data_d;

    logic [9*PIX_W-1:0] win_flat;
    logic [7:0]         code;
    logic [3:0]         rd_total;
    logic               rd_req, rd_acc, res_acc, last_cap;
    logic [ROW_W-1:0]   a_row;
    logic [COL_W-1:0]   a_col;

    assign rd_total = (state_q == FILL) ? 4'd9 : 4'd3;
    assign rd_acc   = rd_req && bus.gray_ready;
    assign res_acc  = (state_q == EMIT) && bus.lbp_ready;
    assign last_cap = cap_vld_q && cap_last_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (start) state_d = FILL;
            FILL, SHIFT: if (last_cap) state_d = EMIT;
            EMIT: begin
                if (res_acc) begin
                    if (col_q < COL_LAST)      state_d = SHIFT;
                    else if (row_q < ROW_LAST) state_d = FILL;
                    else                       state_d = DONE;
                end
            end
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        busy          = (state_q != IDLE);
        finish        = (state_q == DONE);
        bus.lbp_valid = (state_q == EMIT);
        // Requests only in FILL/SHIFT, so nothing is fetched while a result waits.
        rd_req        = ((state_q == FILL) || (state_q == SHIFT)) && (rd_cnt_q < rd_total);
        a_row         = row_q + ROW_W'(rd_r_q) - ROW_W'(1);
        a_col         = col_q + COL_W'(rd_c_q) - COL_W'(1);
        bus.gray_req  = rd_req;
        bus.gray_addr = rd_req ? {a_row, a_col} : '0;
        bus.lbp_addr  = lbp_addr_q;
        bus.lbp_data  = lbp_data_q;
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        rd_r_d     = rd_r_q;
        rd_c_d     = rd_c_q;
        rd_cnt_d   = rd_cnt_q;
        mode_d     = mode_q;
        thr_d      = thr_q;
        win_d      = win_q;
        lbp_addr_d = lbp_addr_q;
        lbp_data_d = lbp_data_q;
        // Read data returns the cycle after accept; remember where it goes.
        cap_vld_d  = rd_acc;
        cap_last_d = rd_acc && (rd_cnt_q == rd_total - 4'd1);
        cap_r_d    = rd_r_q;
        cap_c_d    = rd_c_q;

        // Reads walk each window column top to bottom, then move right.
        if (rd_acc) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_r_q == 2'd2) begin
                rd_r_d = 2'd0;
                rd_c_d = rd_c_q + 2'd1;
            end else begin
                rd_r_d = rd_r_q + 2'd1;
            end
        end

        if (cap_vld_q) win_d[cap_r_q][cap_c_q] = bus.gray_data;

        // The code is taken from the window including the datum landing now,
        // so the result is presented the cycle after the last capture.
        if (last_cap) begin
            lbp_data_d = code;
            lbp_addr_d = {row_q, col_q};
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d    = ROW_W'(1);
                    col_d    = COL_W'(1);
                    mode_d   = mode;
                    thr_d    = thr;
                    rd_r_d   = 2'd0;
                    rd_c_d   = 2'd0;
                    rd_cnt_d = 4'd0;
                end
            end
            EMIT: begin
                if (res_acc) begin
                    rd_r_d   = 2'd0;
                    rd_cnt_d = 4'd0;
                    if (col_q < COL_LAST) begin
                        // Step right: slide window, refetch only the right column.
                        col_d  = col_q + COL_W'(1);
                        rd_c_d = 2'd2;
                        for (int r = 0; r < 3; r++) begin
                            win_d[r][0] = win_q[r][1];
                            win_d[r][1] = win_q[r][2];
                        end
                    end else if (row_q < ROW_LAST) begin
                        row_d  = row_q + ROW_W'(1);
                        col_d  = COL_W'(1);
                        rd_c_d = 2'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win_flat[(r*3+c)*PIX_W +: PIX_W] = win_d[r][c];
    end

    lbp_cmp #(.PIX_W(PIX_W)) u_cmp (
        .win  (win_flat),
        .mode (mode_q),
        .thr  (thr_q),
        .code (code)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q      <= '0;
            col_q      <= '0;
            rd_r_q     <= '0;
            rd_c_q     <= '0;
            rd_cnt_q   <= '0;
            cap_vld_q  <= 1'b0;
            cap_last_q <= 1'b0;
            cap_r_q    <= '0;
            cap_c_q    <= '0;
            mode_q     <= 1'b0;
            thr_q      <= '0;
            win_q      <= '{default: '0};
            lbp_addr_q <= '0;
            lbp_data_q <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            rd_r_q     <= rd_r_d;
            rd_c_q     <= rd_c_d;
            rd_cnt_q   <= rd_cnt_d;
            cap_vld_q  <= cap_vld_d;
            cap_last_q <= cap_last_d;
            cap_r_q    <= cap_r_d;
            cap_c_q    <= cap_c_d;
            mode_q     <= mode_d;
            thr_q      <= thr_d;
            win_q      <= win_d;
            lbp_addr_q <= lbp_addr_d;
            lbp_data_q <= lbp_data_d;
        end
    end

endmodule

// File: tb/tb_lbp_param.sv
// ---------------------------------------------------------------------------
// tb_lbp_param
// Table-driven bench for lbp_param on an 8x8 image: each table row loads an
// image, runs a frame and checks result count, addresses, codes, read count
// and the finish pulse; hand-written sequences cover backpressure with
// random read stalls and reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_lbp_param;

    localparam int W      = 8;
    localparam int H      = 8;
    localparam int AW     = 6;
    localparam int NRES   = 36;
    localparam int NRD    = 144;
    localparam int BUDGET = 4000;

    typedef struct {
        string      name;
        logic       ramp;   // 1: gray = col; 0: flat bg with ctr at address 27
        logic       md;
        logic [7:0] th;
        logic [7:0] bg;
        logic [7:0] ctr;
        logic       all;    // 1: every result must equal ex; 0: only the (3,3) result
        logic [7:0] ex;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] thr = 8'd0;
    logic       busy, finish;

    lbp_if #(.PIX_W(8), .ADDR_W(AW)) bus();

    lbp_param #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .thr    (thr),
        .busy   (busy),
        .finish (finish),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [64];
    logic [5:0] res_addr [$];
    logic [7:0] res_data [$];
    int rd_total = 0;
    int fin_cnt = 0;
    int stab_err = 0;
    int emit_rd_err = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic rnd_gr = 1'b0;
    logic stall_md = 1'b0;
    vec_t v [8];

    // Memory model: data one cycle after accept.
    always @(posedge clk) begin
        if (bus.gray_req && bus.gray_ready) begin
            bus.gray_data <= mem[bus.gray_addr];
            rd_total      <= rd_total + 1;
        end
    end

    // Ready driver, updated just after each rising edge.
    initial begin
        int stall_cnt;
        stall_cnt      = 0;
        bus.gray_ready = 1'b1;
        bus.lbp_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.gray_ready = rnd_gr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!stall_md) begin
                bus.lbp_ready = 1'b1;
            end else if (bus.lbp_valid) begin
                if (stall_cnt == 5) begin
                    bus.lbp_ready = 1'b1;
                    stall_cnt     = 0;
                end else begin
                    bus.lbp_ready = 1'b0;
                    stall_cnt     = stall_cnt + 1;
                end
            end else begin
                bus.lbp_ready = 1'b0;
            end
        end
    end

    // Monitor on the falling edge: results, finish pulses, stability.
    initial begin
        logic       pv_stall, pg_stall;
        logic [5:0] pv_addr, pg_addr;
        logic [7:0] pv_data;
        pv_stall = 1'b0;
        pg_stall = 1'b0;
        pv_addr  = '0;
        pg_addr  = '0;
        pv_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv_stall = 1'b0;
                pg_stall = 1'b0;
            end else begin
                if (bus.lbp_valid && bus.gray_req) emit_rd_err = emit_rd_err + 1;
                if (pv_stall && (!bus.lbp_valid || bus.lbp_addr != pv_addr || bus.lbp_data != pv_data))
                    stab_err = stab_err + 1;
                if (pg_stall && (!bus.gray_req || bus.gray_addr != pg_addr))
                    stab_err = stab_err + 1;
                if (bus.lbp_valid && bus.lbp_ready) begin
                    res_addr.push_back(bus.lbp_addr);
                    res_data.push_back(bus.lbp_data);
                end
                if (finish) fin_cnt = fin_cnt + 1;
                pv_stall = bus.lbp_valid && !bus.lbp_ready;
                pv_addr  = bus.lbp_addr;
                pv_data  = bus.lbp_data;
                pg_stall = bus.gray_req && !bus.gray_ready;
                pg_addr  = bus.gray_addr;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic ramp, input logic md,
                                input logic [7:0] th, input logic [7:0] bg,
                                input logic [7:0] ctr, input logic all, input logic [7:0] ex);
        vec_t r;
        r.name = nm; r.ramp = ramp; r.md = md; r.th = th;
        r.bg = bg; r.ctr = ctr; r.all = all; r.ex = ex;
        return r;
    endfunction

    task automatic fill_img(input logic ramp, input logic [7:0] bg, input logic [7:0] ctr);
        for (int a = 0; a < 64; a++)
            mem[a] = ramp ? 8'(a % W) : ((a == 27) ? ctr : bg);
    endtask

    task automatic start_frame(input logic m, input logic [7:0] t);
        @(posedge clk);
        #1;
        mode  = m;
        thr   = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // first_v: cycles after the start-accepting edge until lbp_valid is seen.
    task automatic wait_frame(output int first_v, output logic done);
        first_v = -1;
        done    = 1'b0;
        for (int k = 1; k <= BUDGET && !done; k++) begin
            @(posedge clk);
            #2;
            if (first_v < 0 && bus.lbp_valid) first_v = k;
            if (finish) done = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string nm, input int rb, input int rdb, input int fb,
                               input logic done, input logic all, input logic [7:0] ex);
        int cnt, aerr, derr;
        logic [31:0] spot;
        check({nm, "_done"}, 32'(done), 32'd1);
        cnt = res_addr.size() - rb;
        check({nm, "_nres"}, 32'(cnt), 32'(NRES));
        aerr = 0;
        for (int i = 0; i < cnt && i < NRES; i++)
            if (res_addr[rb+i] != 6'(((i / 6) + 1) * W + (i % 6) + 1)) aerr = aerr + 1;
        check({nm, "_addr_errs"}, 32'(aerr), 32'd0);
        if (all) begin
            derr = 0;
            for (int i = 0; i < cnt; i++)
                if (res_data[rb+i] !== ex) derr = derr + 1;
            check({nm, "_code_errs"}, 32'(derr), 32'd0);
        end else begin
            spot = (cnt > 14) ? 32'(res_data[rb+14]) : 32'hDEAD;
            check({nm, "_code33"}, spot, 32'(ex));
        end
        check({nm, "_reads"}, 32'(rd_total - rdb), 32'(NRD));
        check({nm, "_finish"}, 32'(fin_cnt - fb), 32'd1);
        check({nm, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int   rb, rdb, fb, sb, eb, fv;
        logic done, got;

        v[0] = mk("flat50",    1'b0, 1'b0, 8'd0,   8'd50,  8'd50,  1'b1, 8'hFF);
        v[1] = mk("ramp_m0",   1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 8'hD6);
        v[2] = mk("ramp_m1t1", 1'b1, 1'b1, 8'd1,   8'd0,   8'd0,   1'b1, 8'h94);
        v[3] = mk("thr_109",   1'b0, 1'b1, 8'd10,  8'd109, 8'd100, 1'b0, 8'h00);
        v[4] = mk("thr_110",   1'b0, 1'b1, 8'd10,  8'd110, 8'd100, 1'b0, 8'hFF);
        v[5] = mk("nowrap",    1'b0, 1'b1, 8'd10,  8'd255, 8'd250, 1'b0, 8'h00);
        v[6] = mk("m0_below",  1'b0, 1'b0, 8'd0,   8'd49,  8'd50,  1'b0, 8'h00);
        v[7] = mk("thr_edge",  1'b0, 1'b1, 8'd200, 8'd255, 8'd55,  1'b0, 8'hFF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 32'({bus.gray_req, bus.lbp_valid, busy, finish}), 32'd0);
        check("rst_gaddr", 32'(bus.gray_addr), 32'd0);
        check("rst_laddr", 32'(bus.lbp_addr), 32'd0);
        check("rst_ldata", 32'(bus.lbp_data), 32'd0);
        reset = 1'b0;

        // Table of frames
        for (int i = 0; i < 8; i++) begin
            fill_img(v[i].ramp, v[i].bg, v[i].ctr);
            rb  = res_addr.size();
            rdb = rd_total;
            fb  = fin_cnt;
            start_frame(v[i].md, v[i].th);
            wait_frame(fv, done);
            check_frame(v[i].name, rb, rdb, fb, done, v[i].all, v[i].ex);
            if (i == 0) check("first_latency", 32'(fv), 32'd10);
        end

        // Backpressure + random read stalls; mid-frame start/mode/thr changes ignored
        rnd_gr   = 1'b1;
        stall_md = 1'b1;
        fill_img(1'b1, 8'd0, 8'd0);
        rb  = res_addr.size();
        rdb = rd_total;
        fb  = fin_cnt;
        sb  = stab_err;
        eb  = emit_rd_err;
        start_frame(1'b0, 8'd0);
        repeat (30) @(posedge clk);
        #1;
        mode  = 1'b1;
        thr   = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_frame(fv, done);
        check_frame("stall", rb, rdb, fb, done, 1'b1, 8'hD6);
        check("stall_stability", 32'(stab_err - sb), 32'd0);
        check("stall_emit_reads", 32'(emit_rd_err - eb), 32'd0);
        rnd_gr   = 1'b0;
        stall_md = 1'b0;
        mode     = 1'b0;
        thr      = 8'd0;

        // Reset in the middle of a frame
        fill_img(1'b1, 8'd0, 8'd0);
        rb = res_addr.size();
        start_frame(1'b0, 8'd0);
        got = 1'b0;
        for (int k = 0; k < BUDGET && !got; k++) begin
            @(posedge clk);
            #2;
            if (res_addr.size() - rb >= 10) got = 1'b1;
        end
        check("midrst_reached10", 32'(got), 32'd1);
        fb    = fin_cnt;
        reset = 1'b1;
        #1;
        check("midrst_ctl", 32'({bus.gray_req, bus.lbp_valid, busy, finish}), 32'd0);
        check("midrst_gaddr", 32'(bus.gray_addr), 32'd0);
        check("midrst_laddr", 32'(bus.lbp_addr), 32'd0);
        check("midrst_ldata", 32'(bus.lbp_data), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_finish", 32'(fin_cnt - fb), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        rb  = res_addr.size();
        rdb = rd_total;
        fb  = fin_cnt;
        start_frame(1'b0, 8'd0);
        wait_frame(fv, done);
        check_frame("after_rst", rb, rdb, fb, done, 1'b1, 8'hD6);
        check("after_rst_latency", 32'(fv), 32'd10);

        check("total_emit_reads", 32'(emit_rd_err), 32'd0);
        check("total_stability", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
